// File: rtl/arbiter_rr_if.sv
// Arbiter request/grant bundle.
// master: drives request; slave: returns grant, grant_valid, grant_id, preempt, D_PRIORITY.
interface arbiter_rr_if #(
    parameter int N_MASTERS = 4,
    parameter int ID_W      = $clog2(N_MASTERS)
);
    logic [N_MASTERS-1:0] request;
    logic [N_MASTERS-1:0] grant;
    logic                 grant_valid;
    logic [ID_W-1:0]      grant_id;
    logic                 preempt;
    logic [ID_W-1:0]      D_PRIORITY;

    modport master (
        output request,
        input  grant,
        input  grant_valid,
        input  grant_id,
        input  preempt,
        input  D_PRIORITY
    );

    modport slave (
        input  request,
        output grant,
        output grant_valid,
        output grant_id,
        output preempt,
        output D_PRIORITY
    );
endinterface

// File: rtl/arbiter_rr.sv
// Round-robin arbiter with optional grant-tenure timeout (preemption).
// Ports: clk, rst (async, active high), bus (arbiter_rr_if.slave).
module arbiter_rr #(
    parameter int N_MASTERS = 4,
    parameter int MAX_HOLD  = 0,
    parameter int ID_W      = $clog2(N_MASTERS)
) (
    input  logic         clk,
    input  logic         rst,
    arbiter_rr_if.slave  bus
);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_OWNED = 1'b1;

    localparam logic [7:0] HOLD_LIM =
        (MAX_HOLD > 0) ? 8'(MAX_HOLD - 1) : 8'd0;

    localparam logic [N_MASTERS-1:0] ONE =
        {{(N_MASTERS-1){1'b0}}, 1'b1};

    logic [0:0]           state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [7:0]           hold_q, hold_d;
    logic                 preempt_q, preempt_d;

    logic [ID_W-1:0]      owner;
    logic [ID_W-1:0]      nxt_ptr;
    logic                 owner_req;
    logic                 other_req;
    logic                 timeout;
    logic [N_MASTERS-1:0] pick;
    logic                 found;
    logic [N_MASTERS-1:0] rot;

    // Encode the one-hot grant register into an index.
    always_comb begin
        owner = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant_q[i]) owner = ID_W'(i);
        end
    end

    assign nxt_ptr   = ID_W'((int'(owner) + 1) % N_MASTERS);
    assign owner_req = |(bus.request & grant_q);
    assign other_req = |(bus.request & ~grant_q);

    // Timeout only when someone else is actually waiting.
    assign timeout = (MAX_HOLD > 0) && (hold_q == HOLD_LIM)
                     && owner_req && other_req;

    // First requester at or after ptr, wrapping modulo N_MASTERS.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        rot   = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            rot = bus.request >> ((int'(ptr_q) + k) % N_MASTERS);
            if (!found && rot[0]) begin
                found = 1'b1;
                pick  = ONE << ((int'(ptr_q) + k) % N_MASTERS);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    hold_d  = 8'd0;
                    state_d = S_OWNED;
                end
            end
            S_OWNED: begin
                // Release wins over a coincident timeout.
                if (!owner_req) begin
                    grant_d = '0;
                    ptr_d   = nxt_ptr;
                    state_d = S_IDLE;
                end else if (timeout) begin
                    grant_d   = '0;
                    ptr_d     = nxt_ptr;
                    preempt_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= 8'd0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = |grant_q;
    assign bus.grant_id    = owner;
    assign bus.preempt     = preempt_q;
    assign bus.D_PRIORITY  = ptr_q;
endmodule

// File: tb/tb_arbiter_rr.sv
// Directed bench for arbiter_rr: vector table on a no-timeout instance,
// hand sequences on a MAX_HOLD=4 instance.
module tb_arbiter_rr;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    arbiter_rr_if #(.N_MASTERS(4)) ifa ();
    arbiter_rr_if #(.N_MASTERS(4)) ifb ();

    arbiter_rr #(.N_MASTERS(4), .MAX_HOLD(0)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    arbiter_rr #(.N_MASTERS(4), .MAX_HOLD(4)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] g;
        logic [1:0] id;
        logic [1:0] prio;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chkb(input string nm, input logic [3:0] g,
                        input logic pre, input logic [1:0] prio);
        chk({nm, ".grant"}, {4'd0, ifb.grant}, {4'd0, g});
        chk({nm, ".valid"}, {7'd0, ifb.grant_valid}, {7'd0, |g});
        chk({nm, ".preempt"}, {7'd0, ifb.preempt}, {7'd0, pre});
        chk({nm, ".prio"}, {6'd0, ifb.D_PRIORITY}, {6'd0, prio});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //            req      grant    id     prio
        tbl[0]  = '{4'b1010, 4'b0010, 2'd1, 2'd0};
        tbl[1]  = '{4'b1000, 4'b0000, 2'd0, 2'd2};
        tbl[2]  = '{4'b1000, 4'b1000, 2'd3, 2'd2};
        tbl[3]  = '{4'b1000, 4'b1000, 2'd3, 2'd2};
        tbl[4]  = '{4'b0000, 4'b0000, 2'd0, 2'd0};
        tbl[5]  = '{4'b1001, 4'b0001, 2'd0, 2'd0};
        tbl[6]  = '{4'b1001, 4'b0001, 2'd0, 2'd0};
        tbl[7]  = '{4'b1000, 4'b0000, 2'd0, 2'd1};
        tbl[8]  = '{4'b0000, 4'b0000, 2'd0, 2'd1};
        tbl[9]  = '{4'b0101, 4'b0100, 2'd2, 2'd1};
        tbl[10] = '{4'b0001, 4'b0000, 2'd0, 2'd3};
        tbl[11] = '{4'b0011, 4'b0001, 2'd0, 2'd3};
        tbl[12] = '{4'b0000, 4'b0000, 2'd0, 2'd1};
        tbl[13] = '{4'b1111, 4'b0010, 2'd1, 2'd1};
        tbl[14] = '{4'b1111, 4'b0010, 2'd1, 2'd1};

        rst = 1'b1;
        ifa.request = '0;
        ifb.request = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.a.grant", {4'd0, ifa.grant}, 8'd0);
        chk("rst.a.id", {6'd0, ifa.grant_id}, 8'd0);
        chk("rst.a.prio", {6'd0, ifa.D_PRIORITY}, 8'd0);
        chkb("rst.b", 4'b0000, 1'b0, 2'd0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            ifa.request = tbl[i].req;
            step();
            chk($sformatf("v%0d.grant", i), {4'd0, ifa.grant},
                {4'd0, tbl[i].g});
            chk($sformatf("v%0d.valid", i), {7'd0, ifa.grant_valid},
                {7'd0, |tbl[i].g});
            chk($sformatf("v%0d.id", i), {6'd0, ifa.grant_id},
                {6'd0, tbl[i].id});
            chk($sformatf("v%0d.prio", i), {6'd0, ifa.D_PRIORITY},
                {6'd0, tbl[i].prio});
            chk($sformatf("v%0d.preempt", i), {7'd0, ifa.preempt},
                8'd0);
        end
        ifa.request = '0;

        // Timeout preemption of master 0 by master 2.
        ifb.request = 4'b0001;
        step();
        chkb("to.g0", 4'b0001, 1'b0, 2'd0);
        ifb.request = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            step();
            chkb($sformatf("to.h%0d", i), 4'b0001, 1'b0, 2'd0);
        end
        step();
        chkb("to.pre", 4'b0000, 1'b1, 2'd1);
        step();
        chkb("to.next", 4'b0100, 1'b0, 2'd1);
        ifb.request = 4'b0001;
        step();
        chkb("to.rel", 4'b0000, 1'b0, 2'd3);
        step();
        chkb("to.wrap", 4'b0001, 1'b0, 2'd3);

        // Sole requester never times out.
        for (int i = 0; i < 20; i++) begin
            step();
            chkb($sformatf("solo%0d", i), 4'b0001, 1'b0, 2'd3);
        end
        ifb.request = 4'b0000;
        step();
        chkb("solo.rel", 4'b0000, 1'b0, 2'd1);

        // Release coinciding with the timeout edge.
        ifb.request = 4'b0011;
        step();
        chkb("co.g", 4'b0010, 1'b0, 2'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chkb($sformatf("co.h%0d", i), 4'b0010, 1'b0, 2'd1);
        end
        ifb.request = 4'b0001;
        step();
        chkb("co.rel", 4'b0000, 1'b0, 2'd2);
        step();
        chkb("co.next", 4'b0001, 1'b0, 2'd2);

        // Async reset mid-tenure of master 2.
        ifb.request = 4'b0100;
        step();
        chkb("ar.rel", 4'b0000, 1'b0, 2'd1);
        step();
        chkb("ar.g", 4'b0100, 1'b0, 2'd1);
        #1;
        rst = 1'b1;
        #1;
        chkb("ar.rst", 4'b0000, 1'b0, 2'd0);
        chk("ar.rst.id", {6'd0, ifb.grant_id}, 8'd0);
        #3;
        rst = 1'b0;
        ifb.request = 4'b0110;
        step();
        chkb("ar.after", 4'b0010, 1'b0, 2'd0);
        chk("ar.after.id", {6'd0, ifb.grant_id}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/arbiter_rr.md
ARBITER_RR -- requirements
Module: arbiter_rr

Interface
REQ-001 Parameter N_MASTERS, default 4; number of requesting masters, legal range 2..8.
REQ-002 Parameter MAX_HOLD, default 0; maximum grant tenure in cycles while another master waits; 0 disables preemption; legal range 0..255.
REQ-003 Parameter ID_W, default $clog2(N_MASTERS); width of index outputs.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 request  input  N_MASTERS  per-master request level; bit i is master i.
REQ-007 grant  output  N_MASTERS  registered grant, one-hot or zero.
REQ-008 grant_valid  output  1  high when any grant bit is high.
REQ-009 grant_id  output  ID_W  index of the granted master; 0 when grant_valid is low.
REQ-010 preempt  output  1  one-cycle pulse marking a forced release by timeout.
REQ-011 D_PRIORITY  output  ID_W  debug: current round-robin pointer, i.e. the highest-priority master index.

Function
REQ-012 The block SHALL implement two states, IDLE (grant all zero) and OWNED (exactly one grant bit high).
REQ-013 In IDLE with request nonzero, the next edge SHALL grant the first requesting master found scanning ptr, ptr+1, ... modulo N_MASTERS, then enter OWNED with hold_cnt=0.
REQ-014 In IDLE with request zero, the block SHALL stay in IDLE with grant, ptr and hold_cnt unchanged.
REQ-015 In OWNED, while request[owner] stays high and no timeout fires, the grant SHALL stay unchanged and hold_cnt SHALL increment, saturating at 255.
REQ-016 In OWNED, request[owner] low at an edge SHALL clear grant, set ptr to (owner+1) mod N_MASTERS, and enter IDLE.
REQ-017 In OWNED with MAX_HOLD>0, hold_cnt==MAX_HOLD-1, request[owner] high and any other request bit high, the next edge SHALL clear grant, set ptr to (owner+1) mod N_MASTERS, pulse preempt for one cycle, and enter IDLE.
REQ-018 Timeout SHALL NOT fire while the owner is the only requester; hold_cnt continues to saturate.
REQ-019 If owner release and the timeout condition coincide, release SHALL take precedence and preempt SHALL stay low.
REQ-020 Every handover SHALL insert exactly one IDLE cycle (grant zero) between two grants.
REQ-021 Request-to-grant latency from IDLE SHALL be one clock edge.
REQ-022 grant_valid and grant_id SHALL be driven combinationally from the grant register, with no added latency.
REQ-023 A master that is preempted and keeps requesting SHALL be re-arbitrated under normal round-robin and receives no extra priority.
REQ-024 The wrap-around ptr = N_MASTERS-1 followed by a release SHALL yield ptr = 0.

Reset
REQ-025 Asserting rst SHALL immediately set grant=0, grant_valid=0, grant_id=0, preempt=0, ptr=0, hold_cnt=0, state=IDLE, independent of clk.
REQ-026 Reset asserted mid-tenure SHALL drop the grant without a preempt pulse.
REQ-027 After rst deasserts, the first edge with request nonzero SHALL grant the lowest-index requester.

Verification
REQ-028 N=4, MAX_HOLD=0: after reset, request=4'b1010 -> next edge grant=4'b0010, grant_id=1, D_PRIORITY=0.
REQ-029 From REQ-028, drop request[1] -> next edge grant=0 and D_PRIORITY=2; following edge grant=4'b1000, grant_id=3.
REQ-030 N=4: master 3 owns the grant and releases -> D_PRIORITY=0; request=4'b1001 -> next grant=4'b0001.
REQ-031 N=4, MAX_HOLD=4: master 0 owns the grant and holds, master 2 requests -> 4 edges after the grant, grant=0 and preempt=1 for one cycle; next edge grant=4'b0100.
REQ-032 MAX_HOLD=4, only master 0 requests for 20 cycles -> grant=4'b0001 throughout and preempt never asserts.
REQ-033 Assert rst for half a cycle while grant=4'b0100 -> grant=0 immediately; after release, request=4'b0110 -> grant=4'b0010.
